// File: rtl/rtc_7seg_scan_gen2.sv
// Real-time clock (24h/12h) with three set modes and a bit-serial six-digit
// 7-segment scan; one clock domain, all timing from one-cycle enable pulses.
module rtc_7seg_scan_gen2 #(
  parameter int SEC_DIV  = 10_000_000,
  parameter int SCAN_DIV = 5_000,
  parameter int DEB_LEN  = 16,
  parameter int BLINK_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       prog_btn,
  input  logic       adj_btn,
  input  logic       fmt_12h,
  input  logic       seg_pol,
  output logic       seg_bit,
  output logic [2:0] seg_sel,
  output logic [2:0] dig_sel,
  output logic       frame_start,
  output logic       ampm,
  output logic [1:0] mode
);
  // state   | meaning
  // RUN     | time advances on sec_tick, all six digits shown
  // SET_SEC | adj bumps seconds, only s_u/s_t shown
  // SET_MIN | adj bumps minutes, only m_u/m_t shown
  // SET_HR  | adj bumps hours, only h_u/h_t shown; leaving restarts the second
  typedef enum logic [1:0] {RUN = 2'd0, SET_SEC = 2'd1, SET_MIN = 2'd2, SET_HR = 2'd3} mode_e;

  localparam int SW = $clog2(SEC_DIV);
  localparam int CW = $clog2(SCAN_DIV + 1);
  localparam int DW = $clog2(DEB_LEN);
  localparam logic [SW-1:0] SEC_LAST  = SW'(SEC_DIV - 1);
  localparam logic [SW-1:0] SEC_HALF  = SW'(SEC_DIV / 2);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_LEN - 1);

  logic [SW-1:0] sec_cnt_q, sec_cnt_d;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d, edge_q, edge_d;
  logic [DW-1:0] deb_cnt_q [2];
  logic [DW-1:0] deb_cnt_d [2];
  mode_e         mode_q, mode_d;
  logic [3:0]    su_q, su_d, mu_q, mu_d;
  logic [2:0]    st_q, st_d, mt_q, mt_d;
  logic [4:0]    hr_q, hr_d;
  logic [2:0]    seg_sel_q, seg_sel_d, dig_sel_q, dig_sel_d;
  logic          frame_q, frame_d;

  logic sec_tick, scan_tick, prog_edge, adj_edge;
  logic s_wrap, m_wrap, inc_s, inc_m, inc_h, shown;
  logic [4:0] h_disp;
  logic [3:0] ht, hu, dig_val;
  logic [6:0] glyph;
  logic [7:0] glyph_ext;

  assign sec_tick  = (sec_cnt_q == SEC_LAST);
  assign scan_tick = (scan_cnt_q == SCAN_LAST);
  assign prog_edge = edge_q[0];
  assign adj_edge  = edge_q[1] & ~edge_q[0];

  // Buttons: index 0 = prog, 1 = adj; stability timer reloads whenever the synced level agrees
  always_comb begin
    sync1_d = {adj_btn, prog_btn};
    sync2_d = sync1_q;
    for (int i = 0; i < 2; i++) begin
      deb_d[i]     = deb_q[i];
      edge_d[i]    = 1'b0;
      deb_cnt_d[i] = DEB_LAST;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == '0) begin
          deb_d[i]  = sync2_q[i];
          edge_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (prog_edge) begin
      case (mode_q)
        RUN:     mode_d = SET_SEC;
        SET_SEC: mode_d = SET_MIN;
        SET_MIN: mode_d = SET_HR;
        default: mode_d = RUN;
      endcase
    end
  end

  always_comb begin
    sec_cnt_d  = sec_tick ? '0 : sec_cnt_q + 1'b1;
    scan_cnt_d = scan_tick ? '0 : scan_cnt_q + 1'b1;
    if (prog_edge && mode_q == SET_HR) sec_cnt_d = '0;
  end

  // Set modes bump one field without carrying into the next
  always_comb begin
    su_d = su_q; st_d = st_q; mu_d = mu_q; mt_d = mt_q; hr_d = hr_q;
    s_wrap = (su_q == 4'd9) && (st_q == 3'd5);
    m_wrap = (mu_q == 4'd9) && (mt_q == 3'd5);
    inc_s = ((mode_q == RUN) && sec_tick) || ((mode_q == SET_SEC) && adj_edge);
    inc_m = ((mode_q == RUN) && sec_tick && s_wrap) || ((mode_q == SET_MIN) && adj_edge);
    inc_h = ((mode_q == RUN) && sec_tick && s_wrap && m_wrap) || ((mode_q == SET_HR) && adj_edge);
    if (inc_s) begin
      su_d = (su_q == 4'd9) ? 4'd0 : su_q + 4'd1;
      if (su_q == 4'd9) st_d = (st_q == 3'd5) ? 3'd0 : st_q + 3'd1;
    end
    if (inc_m) begin
      mu_d = (mu_q == 4'd9) ? 4'd0 : mu_q + 4'd1;
      if (mu_q == 4'd9) mt_d = (mt_q == 3'd5) ? 3'd0 : mt_q + 3'd1;
    end
    if (inc_h) hr_d = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
  end

  always_comb begin
    seg_sel_d = seg_sel_q;
    dig_sel_d = dig_sel_q;
    frame_d   = 1'b0;
    if (scan_tick) begin
      if (seg_sel_q == 3'd6) begin
        seg_sel_d = 3'd0;
        if (dig_sel_q == 3'd5) begin
          dig_sel_d = 3'd0;
          frame_d   = 1'b1;
        end else begin
          dig_sel_d = dig_sel_q + 3'd1;
        end
      end else begin
        seg_sel_d = seg_sel_q + 3'd1;
      end
    end
  end

  always_comb begin
    if (fmt_12h) begin
      if (hr_q == 5'd0)       h_disp = 5'd12;
      else if (hr_q > 5'd12)  h_disp = hr_q - 5'd12;
      else                    h_disp = hr_q;
    end else begin
      h_disp = hr_q;
    end
    if (h_disp >= 5'd20) begin
      ht = 4'd2; hu = 4'(h_disp - 5'd20);
    end else if (h_disp >= 5'd10) begin
      ht = 4'd1; hu = 4'(h_disp - 5'd10);
    end else begin
      ht = 4'd0; hu = h_disp[3:0];
    end
  end

  // Code 10 is the blank glyph
  always_comb begin
    case (dig_sel_q)
      3'd0:    dig_val = su_q;
      3'd1:    dig_val = {1'b0, st_q};
      3'd2:    dig_val = mu_q;
      3'd3:    dig_val = {1'b0, mt_q};
      3'd4:    dig_val = hu;
      3'd5:    dig_val = (fmt_12h && ht == 4'd0) ? 4'd10 : ht;
      default: dig_val = 4'd10;
    endcase
    case (mode_q)
      SET_SEC: shown = (dig_sel_q[2:1] == 2'b00);
      SET_MIN: shown = (dig_sel_q[2:1] == 2'b01);
      SET_HR:  shown = (dig_sel_q[2:1] == 2'b10);
      default: shown = 1'b1;
    endcase
    if ((BLINK_EN != 0) && (mode_q != RUN) && (sec_cnt_q < SEC_HALF)) shown = 1'b0;
    if (!shown) dig_val = 4'd10;
    case (dig_val)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0011000;
      default: glyph = 7'b1111111;
    endcase
    glyph_ext = {1'b1, glyph};
  end

  assign seg_bit     = glyph_ext[seg_sel_q] ^ ~seg_pol;
  assign seg_sel     = seg_sel_q;
  assign dig_sel     = dig_sel_q;
  assign frame_start = frame_q;
  assign ampm        = fmt_12h & (hr_q >= 5'd12);
  assign mode        = mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_cnt_q  <= '0;
      scan_cnt_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      edge_q     <= '0;
      deb_cnt_q  <= '{default: DEB_LAST};
      mode_q     <= RUN;
      su_q       <= '0;
      st_q       <= '0;
      mu_q       <= '0;
      mt_q       <= '0;
      hr_q       <= '0;
      seg_sel_q  <= '0;
      dig_sel_q  <= '0;
      frame_q    <= 1'b0;
    end else begin
      sec_cnt_q  <= sec_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      edge_q     <= edge_d;
      deb_cnt_q  <= deb_cnt_d;
      mode_q     <= mode_d;
      su_q       <= su_d;
      st_q       <= st_d;
      mu_q       <= mu_d;
      mt_q       <= mt_d;
      hr_q       <= hr_d;
      seg_sel_q  <= seg_sel_d;
      dig_sel_q  <= dig_sel_d;
      frame_q    <= frame_d;
    end
  end
endmodule

// File: tb/tb_rtc_7seg_scan_gen2.sv
// Bench for rtc_7seg_scan_gen2: randomized button presses and display settings checked
// against a seconds-of-day reference model of time, mode and the segment scan.
`timescale 1ns/1ps
module tb_rtc_7seg_scan_gen2;
  localparam int SEC_DIV  = 10;
  localparam int SCAN_DIV = 2;
  localparam int DEB_LEN  = 3;
  localparam int BLINK_EN = 0;
  localparam logic [6:0] GLYPH [11] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0011000, 7'b1111111};

  logic clk = 1'b0, rst = 1'b1, prog_btn = 1'b0, adj_btn = 1'b0, fmt_12h = 1'b0, seg_pol = 1'b0;
  logic seg_bit, frame_start, ampm;
  logic [2:0] seg_sel, dig_sel;
  logic [1:0] mode;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int m_mode = 0, e_mode = 0, m_base = 0, m_ref = 0, m_sref = 0;
  logic [1:0] prev_mode = 2'd0;
  bit chk_en = 1'b1;

  rtc_7seg_scan_gen2 #(.SEC_DIV(SEC_DIV), .SCAN_DIV(SCAN_DIV), .DEB_LEN(DEB_LEN), .BLINK_EN(BLINK_EN)) dut (
    .clk(clk), .rst(rst), .prog_btn(prog_btn), .adj_btn(adj_btn), .fmt_12h(fmt_12h),
    .seg_pol(seg_pol), .seg_bit(seg_bit), .seg_sel(seg_sel), .dig_sel(dig_sel),
    .frame_start(frame_start), .ampm(ampm), .mode(mode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int now_t();
    if (m_mode == 0) return (m_base + (cyc - m_ref) / SEC_DIV) % 86400;
    return m_base;
  endfunction

  function automatic int bump(input int t, input int f);
    int s, mi, h;
    s = t % 60; mi = (t / 60) % 60; h = t / 3600;
    case (f)
      1:       s  = (s + 1) % 60;
      2:       mi = (mi + 1) % 60;
      default: h  = (h + 1) % 24;
    endcase
    return h * 3600 + mi * 60 + s;
  endfunction

  function automatic logic exp_seg(input int t, input int d, input int s);
    int h, hv, v;
    logic [6:0] g;
    h  = t / 3600;
    hv = fmt_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
    case (d)
      0:       v = (t % 60) % 10;
      1:       v = (t % 60) / 10;
      2:       v = ((t / 60) % 60) % 10;
      3:       v = ((t / 60) % 60) / 10;
      4:       v = hv % 10;
      default: v = (fmt_12h && hv < 10) ? 10 : hv / 10;
    endcase
    if (m_mode != 0 && d / 2 != m_mode - 1) v = 10;
    g = GLYPH[v];
    return seg_pol ? g[s] : ~g[s];
  endfunction

  // One clock: follow observed mode changes into the model, then compare
  task automatic step();
    int n, st, t;
    @(negedge clk);
    if (mode !== prev_mode) begin
      if (m_mode == 0) m_base = now_t();
      m_mode = int'(mode);
      if (m_mode == 0) m_ref = cyc;
      prev_mode = mode;
    end
    n  = cyc - m_sref;
    st = n / SCAN_DIV;
    chk("seg_sel", 32'(seg_sel), st % 7);
    chk("dig_sel", 32'(dig_sel), (st / 7) % 6);
    chk("frame_start", 32'(frame_start), (n > 0 && n % SCAN_DIV == 0 && st % 42 == 0) ? 1 : 0);
    if (chk_en) begin
      t = now_t();
      chk("seg_bit", 32'(seg_bit), 32'(exp_seg(t, (st / 7) % 6, st % 7)));
      chk("ampm", 32'(ampm), (fmt_12h && t >= 43200) ? 1 : 0);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      if ($urandom_range(0, 19) == 0) seg_pol = 1'($urandom);
      step();
    end
  endtask

  task automatic press(input logic p, input logic a, input int hi);
    bit pv, av;
    chk_en = 1'b0;
    prog_btn = p; adj_btn = a;
    repeat (hi) step();
    prog_btn = 1'b0; adj_btn = 1'b0;
    repeat (8) step();
    pv = p && (hi >= DEB_LEN);
    av = a && (hi >= DEB_LEN) && !pv;
    if (pv) e_mode = (e_mode + 1) % 4;
    else if (av && e_mode != 0) m_base = bump(m_base, e_mode);
    chk("mode", 32'(mode), e_mode);
    chk_en = 1'b1;
  endtask

  task automatic prog_press();
    press(1'b1, 1'b0, $urandom_range(6, 9));
  endtask

  task automatic adj_n(input int n);
    repeat (n) press(1'b0, 1'b1, $urandom_range(6, 9));
  endtask

  task automatic set_time(input int h, input int mi, input int s);
    prog_press();
    adj_n((s - m_base % 60 + 60) % 60);
    prog_press();
    adj_n((mi - (m_base / 60) % 60 + 60) % 60);
    prog_press();
    adj_n((h - m_base / 3600 + 24) % 24);
    prog_press();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_mode = 0; e_mode = 0; m_base = 0; m_ref = cyc; m_sref = cyc; prev_mode = 2'd0;
    chk("rst_mode", 32'(mode), 0);
    chk("rst_seg_sel", 32'(seg_sel), 0);
    chk("rst_dig_sel", 32'(dig_sel), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_ampm", 32'(ampm), 0);
  endtask

  initial begin
    int cnt;
    seg_pol = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();

    // Digit 0 at 00:00:00, active-low segments a..g; seg 5 lands after the first tick
    for (int k = 0; k < 7; k++) begin
      step();
      if (k != 5) chk("dig0_seg", 32'(seg_bit), (k == 6) ? 1 : 0);
      step();
    end

    cnt = 0;
    while (frame_start !== 1'b1 && cnt < 200) begin step(); cnt++; end
    chk("frame_seen", 32'(frame_start), 1);
    cnt = 0;
    do begin step(); cnt++; end while (frame_start !== 1'b1 && cnt < 200);
    chk("frame_period", cnt, 84);

    // Glitch then clean prog press
    press(1'b1, 1'b0, 2);
    run(20);
    prog_press();
    run(30);

    // 61 presses wrap seconds by one; time frozen meanwhile
    adj_n(61);
    run(90);
    press(1'b1, 1'b1, 7);
    run(30);
    prog_press();
    prog_press();
    run(100);
    press(1'b0, 1'b1, 7);
    run(100);

    // Midnight rollover
    fmt_12h = 1'($urandom);
    set_time(23, 59, 59);
    run(120);

    // Hour formatting
    fmt_12h = 1'b1;
    set_time(0, $urandom_range(0, 59), $urandom_range(0, 59));
    run(100);
    set_time(13, $urandom_range(0, 59), $urandom_range(0, 59));
    run(100);
    fmt_12h = 1'b0;
    run(100);
    set_time(23, $urandom_range(0, 59), $urandom_range(0, 59));
    run(100);
    fmt_12h = 1'b1;
    set_time(12, $urandom_range(0, 59), $urandom_range(0, 59));
    run(100);

    // Reset while in SET_MIN at 12:34:56
    prog_press();
    adj_n((56 - m_base % 60 + 60) % 60);
    prog_press();
    adj_n((34 - (m_base / 60) % 60 + 60) % 60);
    run(90);
    do_reset();
    run(150);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
